// File: rtl/bcd_seven_seg_scan.sv
// bcd_seven_seg_scan
//   Time-multiplexed driver for a 3-digit common-anode seven-segment display.
//   Each digit owns a slot of REFRESH_COUNT cycles. The first BLANK_CYCLES of a
//   slot keep all anodes off so the previous digit's segments cannot ghost.
//   New BCD words are staged in a pending register and moved to the display
//   register only when the hundreds slot ends, so a frame never mixes values.
//
// Ports
//   i_Clk         system clock, rising edge
//   i_Reset       asynchronous active-high reset
//   i_BCD[11:0]   {hundreds, tens, units} BCD nibbles
//   i_Valid       one-cycle strobe, i_BCD sampled when high
//   o_Anode[2:0]  active-low digit enables (bit0 units .. bit2 hundreds)
//   o_Seg[6:0]    active-low segments {g,f,e,d,c,b,a}
//   o_Frame_Tick  one-cycle pulse after the hundreds slot ends
//
// Build option
//   LEADING_ZERO_BLANK_EN : blank a zero hundreds digit, and a zero tens digit
//   when hundreds is also zero. The anode is still driven for a blanked slot.

module bcd_seven_seg_scan #(
  parameter int REFRESH_COUNT = 100000,
  parameter int BLANK_CYCLES  = 1000
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [11:0] i_BCD,
  input  logic        i_Valid,
  output logic [2:0]  o_Anode,
  output logic [6:0]  o_Seg,
  output logic        o_Frame_Tick
);

  localparam int            CW        = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
  localparam logic [CW-1:0] LAST      = CW'(REFRESH_COUNT - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [6:0]    SEG_OFF   = 7'b1111111;
  localparam logic [6:0]    SEG_DASH  = 7'b0111111;

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic          slot_end, frame_end;

  logic [11:0]   pend, disp;
  logic          pend_flag;

  logic [3:0]    nib;
  logic          lz_blank;
  logic [2:0]    anode_d;
  logic [6:0]    seg_d;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = SEG_DASH;
    endcase
  endfunction

  // Scan sequencing plus the output decode for the slot position currently
  // held in cnt/idx/state; the result is registered below.
  always_comb begin
    slot_end  = (cnt == LAST);
    frame_end = slot_end && (idx == 2'd2);
    cnt_nxt   = slot_end ? '0 : cnt + CW'(1);
    idx_nxt   = idx;
    if (slot_end) idx_nxt = frame_end ? 2'd0 : idx + 2'd1;
    // State tracks the counter value it will sit beside after the edge.
    state_nxt = (cnt_nxt < BLANK_END) ? S_BLANK : S_DRIVE;

    case (idx)
      2'd1:    nib = disp[7:4];
      2'd2:    nib = disp[11:8];
      default: nib = disp[3:0];
    endcase

    lz_blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // Only true zeros are suppressed, so invalid nibbles still show a dash.
    lz_blank = ((idx == 2'd2) && (disp[11:8] == 4'd0)) ||
               ((idx == 2'd1) && (disp[11:4] == 8'd0));
`endif

    anode_d = 3'b111;
    seg_d   = SEG_OFF;
    if (state == S_DRIVE) begin
      anode_d = ~(3'b001 << idx);
      seg_d   = lz_blank ? SEG_OFF : decode(nib);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state <= S_BLANK;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // A strobe landing on the frame edge refills pending and keeps the flag set,
  // while the older pending value moves to the display.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      pend      <= 12'h000;
      disp      <= 12'h000;
      pend_flag <= 1'b0;
    end else begin
      if (frame_end && pend_flag) disp <= pend;
      if (i_Valid) begin
        pend      <= i_BCD;
        pend_flag <= 1'b1;
      end else if (frame_end) begin
        pend_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Anode      <= 3'b111;
      o_Seg        <= SEG_OFF;
      o_Frame_Tick <= 1'b0;
    end else begin
      o_Anode      <= anode_d;
      o_Seg        <= seg_d;
      o_Frame_Tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_bcd_seven_seg_scan.sv
// Bench for bcd_seven_seg_scan with REFRESH_COUNT=8, BLANK_CYCLES=2.
// Strobed values are queued with the frame they should first appear in; each
// cycle the queue is drained up to the current frame and the outputs are
// compared against a timing model based on the cycle count since reset.
`timescale 1ns/1ps

module tb_bcd_seven_seg_scan;

  localparam int RC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 3 * RC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] bcd = 12'h000;
  logic        vld = 1'b0;
  logic [2:0]  anode;
  logic [6:0]  seg;
  logic        tick;

  bcd_seven_seg_scan #(.REFRESH_COUNT(RC), .BLANK_CYCLES(BC)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_BCD(bcd), .i_Valid(vld),
    .o_Anode(anode), .o_Seg(seg), .o_Frame_Tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          frame;
    logic [11:0] bcd;
  } sb_t;

  sb_t         q[$];
  logic [11:0] cur_disp;
  int          t;
  int          checks = 0;
  int          errors = 0;
  int          ticks;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [6:0] digit_seg(input logic [11:0] v, input int d);
    logic [3:0] n;
    n = v[4*d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    if (d == 2 && v[11:8] == 4'd0) return 7'b1111111;
    if (d == 1 && v[11:4] == 8'd0) return 7'b1111111;
`endif
    return dec(n);
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    t = 0;
    q.delete();
    cur_disp = 12'h000;
  endtask

  // Advance n cycles; pop scoreboard entries due by now and compare outputs.
  task automatic run_cycles(input int n, input string name);
    int          c, slot, pos, f;
    logic [2:0]  ea;
    logic [6:0]  es;
    logic        et;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      t++;
      c = t - 1;
      f = c / FRAME;
      while (q.size() > 0 && q[0].frame <= f) cur_disp = q.pop_front().bcd;
      slot = (c / RC) % 3;
      pos  = c % RC;
      if (pos < BC) begin
        ea = 3'b111;
        es = 7'b1111111;
      end else begin
        ea = 3'b111;
        ea[slot] = 1'b0;
        es = digit_seg(cur_disp, slot);
      end
      et = (t % FRAME == 0);
      if (tick) ticks++;
      checks += 3;
      if (anode !== ea) begin
        errors++;
        $display("FAIL %s anode t=%0d got %b exp %b", name, t, anode, ea);
      end
      if (seg !== es) begin
        errors++;
        $display("FAIL %s seg t=%0d got %b exp %b", name, t, seg, es);
      end
      if (tick !== et) begin
        errors++;
        $display("FAIL %s tick t=%0d got %b exp %b", name, t, tick, et);
      end
    end
  endtask

  // One-cycle strobe sampled on the next edge e=t+1; it first shows in the
  // frame after that edge's frame boundary (last strobe per frame wins).
  task automatic strobe(input logic [11:0] v, input string name);
    int k;
    k = (t + 1) / FRAME + 1;
    if (q.size() > 0 && q[$].frame == k) q[$].bcd = v;
    else q.push_back('{frame: k, bcd: v});
    vld = 1'b1;
    bcd = v;
    run_cycles(1, name);
    vld = 1'b0;
  endtask

  task automatic wait_phase(input int mod_t, input string name);
    int guard = 0;
    while ((t % FRAME) != mod_t && guard < 2 * FRAME) begin
      run_cycles(1, name);
      guard++;
    end
    checks++;
    if ((t % FRAME) != mod_t) begin
      errors++;
      $display("FAIL %s align got %0d exp %0d", name, t % FRAME, mod_t);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    checks += 3;
    if (anode !== 3'b111) begin errors++; $display("FAIL reset anode got %b exp 111", anode); end
    if (seg !== 7'b1111111) begin errors++; $display("FAIL reset seg got %b exp 1111111", seg); end
    if (tick !== 1'b0) begin errors++; $display("FAIL reset tick got %b exp 0", tick); end
    run_cycles(FRAME, "reset_idle");
  endtask

  task automatic test_basic();
    strobe(12'h087, "basic");
    run_cycles(3 * FRAME, "basic");
  endtask

  task automatic test_timing();
    ticks = 0;
    run_cycles(2 * FRAME, "timing");
    checks++;
    if (ticks != 2) begin
      errors++;
      $display("FAIL timing tick_count got %0d exp 2", ticks);
    end
  endtask

  task automatic test_last_wins();
    wait_phase(2, "last_wins");
    strobe(12'h255, "last_wins");
    run_cycles(3, "last_wins");
    strobe(12'h123, "last_wins");
    run_cycles(3 * FRAME, "last_wins");
  endtask

  task automatic test_frame_edge();
    wait_phase(4, "frame_edge");
    strobe(12'h0A9, "frame_edge");
    // Next strobe is sampled on the latch edge itself.
    wait_phase(FRAME - 1, "frame_edge");
    strobe(12'h456, "frame_edge");
    run_cycles(3 * FRAME, "frame_edge");
  endtask

  task automatic test_zeros();
    strobe(12'h007, "zeros");
    run_cycles(2 * FRAME, "zeros");
    strobe(12'h900, "zeros");
    run_cycles(2 * FRAME, "zeros");
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    strobe(12'h321, "reset_mid");
    run_cycles(2 * FRAME, "reset_mid");
    while (!(((t - 1) / RC) % 3 == 1 && (t - 1) % RC == 4) && guard < FRAME) begin
      run_cycles(1, "reset_mid");
      guard++;
    end
    rst = 1'b1;
    #1;
    checks += 3;
    if (anode !== 3'b111) begin errors++; $display("FAIL reset_mid anode got %b exp 111", anode); end
    if (seg !== 7'b1111111) begin errors++; $display("FAIL reset_mid seg got %b exp 1111111", seg); end
    if (tick !== 1'b0) begin errors++; $display("FAIL reset_mid tick got %b exp 0", tick); end
    reset_dut();
    run_cycles(BC, "reset_mid_restart");
    checks++;
    if (anode !== 3'b111) begin
      errors++;
      $display("FAIL reset_mid pre_drive anode got %b exp 111", anode);
    end
    run_cycles(1, "reset_mid_restart");
    checks++;
    if (anode !== 3'b110) begin
      errors++;
      $display("FAIL reset_mid first_drive anode got %b exp 110", anode);
    end
    run_cycles(FRAME, "reset_mid_restart");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timing();
    test_last_wins();
    test_frame_edge();
    test_zeros();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_seven_seg_scan.md
Name: bcd_seven_seg_scan

Overview:
- Consumes the registered 12-bit, 3-digit BCD word from the hex-to-decimal converter and drives a 3-digit common-anode seven-segment display.
- Time-multiplexes the digits with a refresh counter.
- Inserts a blanking gap between digits to prevent ghosting.
- Latches new BCD values only at frame boundaries, so the display never tears.

Parameters:
- REFRESH_COUNT, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be > BLANK_CYCLES+1.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be >= 1.

Ports:
- i_Clk  input  1  system clock, rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_BCD  input  12  {hundreds[11:8], tens[7:4], units[3:0]}.
- i_Valid  input  1  one-cycle strobe; i_BCD is sampled when high.
- o_Anode  output  3  active-low digit enables; bit0 = units, bit1 = tens, bit2 = hundreds.
- o_Seg  output  7  active-low segments {g,f,e,d,c,b,a}.
- o_Frame_Tick  output  1  one-cycle pulse at the end of each full 3-digit frame.

Behaviour:
- Reset (async assert, sync release on the next i_Clk edge):
  - o_Anode=3'b111, o_Seg=7'b1111111, o_Frame_Tick=0.
  - Pending and display registers = 12'h000; pending-flag = 0.
  - Digit index = 0, slot counter = 0, state = S_BLANK.
- Input capture:
  - i_Valid=1 -> pending register <= i_BCD, pending-flag <= 1, on that edge.
  - Multiple strobes within one frame: the last one wins.
- Frame latch:
  - Applies on the cycle the slot counter wraps from digit 2 to digit 0.
  - If pending-flag=1: display register <= pending register and pending-flag <= 0.
  - If i_Valid=1 on that same cycle, the new i_BCD goes to the pending register, pending-flag stays 1, and the previous pending value is what gets displayed.
- Slot counter: counts 0..REFRESH_COUNT-1, then wraps to 0 and advances the digit index 0->1->2->0.
- FSM:
  - S_BLANK while counter < BLANK_CYCLES: o_Anode=3'b111, o_Seg=7'b1111111.
  - S_DRIVE otherwise: o_Anode has only bit[index] low; o_Seg = decode of the display-register nibble for that index.
- Outputs are registered, one cycle behind the counter/state. After reset release:
  - o_Anode=3'b110 first appears at cycle BLANK_CYCLES+1.
  - Digit period is exactly REFRESH_COUNT cycles; frame period is 3*REFRESH_COUNT.
- Decode (active low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble 10..15 (invalid BCD) = dash 0111111.
- o_Frame_Tick: high for exactly the cycle on which the digit-2 slot ends (counter = REFRESH_COUNT-1, index = 2), registered.
- Reset asserted mid-slot: outputs go to reset values immediately (asynchronously); the scan restarts from digit 0 in S_BLANK.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Hundreds digit blanked (7'b1111111) when it equals 0.
  - Tens digit blanked when both hundreds and tens equal 0.
  - Units digit always shown.
  - A blanked digit still drives its anode low for its slot.
  - Invalid nibbles are never blanked; they show a dash.
- Not defined: every digit is decoded normally, e.g. 087 shows "0","8","7".

Test Plan (REFRESH_COUNT=8, BLANK_CYCLES=2):
- Reset, then pulse i_Valid with i_BCD=12'h087 -> from the second frame:
  - units slot: o_Anode=110, o_Seg=1111000
  - tens slot: o_Anode=101, o_Seg=0000000
  - hundreds slot: o_Anode=011, o_Seg=1000000
  - o_Frame_Tick pulses every 24 cycles.
- Timing check -> o_Anode=111 for exactly 2 cycles at each slot start and low for 6 cycles; o_Frame_Tick pulses exactly once per 24 cycles.
- i_Valid with 12'h255 then, in the same frame, 12'h123 -> the next frame shows 1,2,3 and never 255; the current frame is unchanged mid-frame.
- i_BCD=12'h0A9 -> units 0010000, tens dash 0111111, hundreds 1000000 (LEADING_ZERO_BLANK_EN undefined).
- With LEADING_ZERO_BLANK_EN defined:
  - i_BCD=12'h007 -> hundreds and tens o_Seg=1111111, units 1111000.
  - i_BCD=12'h087 -> hundreds blank, tens 0000000.
- Assert i_Reset mid tens slot -> same-cycle o_Anode=111, o_Seg=1111111, o_Frame_Tick=0. After release, display shows 000 and units drives first at cycle 3.
